// File: rtl/prbs_pkg.sv
// Shared constants, FSM encoding and seed helper for the PRBS15 pattern
// generator and its matching detector/checker.
package prbs_pkg;

   localparam int PRBS_LEN   = 15;
   localparam int PRBS_TAP_A = 14;
   localparam int PRBS_TAP_B = 13;
   localparam int BYTE_W     = 8;
   localparam logic [PRBS_LEN-1:0] PRBS_SEED_DEF = 15'h0001;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      PAT  = 2'd1,
      PRBS = 2'd2
   } prbs_state_e;

   // An all-zero LFSR state never leaves zero, so substitute the default seed.
   function automatic logic [PRBS_LEN-1:0] prbs_seed(input logic [PRBS_LEN-1:0] raw);
      return (raw == '0) ? PRBS_SEED_DEF : raw;
   endfunction

endpackage

// File: rtl/prbs_lfsr8.sv
// Combinational eight-step unroll of the x^15+x^14+1 LFSR; first generated
// bit lands in data_byte[7]. Shared with the detector's checker.
module prbs_lfsr8
   import prbs_pkg::*;
(
   input  logic [PRBS_LEN-1:0] state,
   output logic [PRBS_LEN-1:0] next_state,
   output logic [BYTE_W-1:0]   data_byte
);

   logic [PRBS_LEN-1:0] s;
   logic                fb;

   always_comb begin
      s         = state;
      fb        = 1'b0;
      data_byte = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         fb = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
         s  = {s[PRBS_LEN-2:0], fb};
         data_byte[BYTE_W-1-i] = fb;
      end
      next_state = s;
   end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Byte stimulus source: sync pattern repeated n times (MSB byte first), then
// free-running PRBS15. Optional bit-0 error injection under PRBS_GEN_ERR_INJ_EN.
module prbs_pattern_gen
   import prbs_pkg::*;
#(
   parameter int PAT_W = 32,
   parameter int N_W   = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [PAT_W-1:0]  pattern,
   input  logic [N_W-1:0]    n,
`ifdef PRBS_GEN_ERR_INJ_EN
   input  logic              inj_err,
`endif
   output logic [BYTE_W-1:0] prbs_out,
   output logic              prbs_valid,
   output logic              pattern_phase,
   output prbs_state_e       dbg_state
);

   localparam int BYTES = PAT_W / BYTE_W;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
   localparam bit SINGLE_BYTE = (BYTES == 1);

   prbs_state_e         state_q, state_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [N_W-1:0]      n_q, n_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_W-1:0]      rep_q, rep_d;
   logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
   logic [BYTE_W-1:0]   out_q, out_d;
   logic                valid_q;
   logic                phase_q, phase_d;

   logic [PRBS_LEN-1:0] step_in, step_next;
   logic [BYTE_W-1:0]   step_byte;

   function automatic logic [BYTE_W-1:0] pat_byte(input logic [PAT_W-1:0] p,
                                                 input logic [IDX_W-1:0] i);
      logic [PAT_W-1:0] sh;
      sh = p << (BYTE_W * i);
      return sh[PAT_W-1 -: BYTE_W];
   endfunction

   prbs_lfsr8 u_lfsr8 (
      .state      (step_in),
      .next_state (step_next),
      .data_byte  (step_byte)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      n_d     = n_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      lfsr_d  = lfsr_q;
      out_d   = out_q;
      phase_d = phase_q;
      step_in = lfsr_q;
      case (state_q)
         LOAD: begin
            pat_d = pattern;
            n_d   = n;
            if (n != '0) begin
               out_d   = pattern[PAT_W-1 -: BYTE_W];
               phase_d = 1'b1;
               idx_d   = SINGLE_BYTE ? '0 : IDX_W'(1);
               rep_d   = SINGLE_BYTE ? N_W'(1) : '0;
               state_d = PAT;
            end else begin
               // Seed and first PRBS byte come out of the same edge.
               step_in = prbs_seed(pattern[PRBS_LEN-1:0]);
               lfsr_d  = step_next;
               out_d   = step_byte;
               phase_d = 1'b0;
               state_d = PRBS;
            end
         end
         PAT: begin
            if (idx_q == '0 && rep_q == n_q) begin
               step_in = prbs_seed(pat_q[PRBS_LEN-1:0]);
               lfsr_d  = step_next;
               out_d   = step_byte;
               phase_d = 1'b0;
               state_d = PRBS;
            end else begin
               out_d   = pat_byte(pat_q, idx_q);
               phase_d = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  rep_d = rep_q + 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         PRBS: begin
            step_in = lfsr_q;
            lfsr_d  = step_next;
            out_d   = step_byte;
         end
         default: state_d = LOAD;
      endcase
`ifdef PRBS_GEN_ERR_INJ_EN
      // Only the registered byte is corrupted; LFSR and counters stay clean.
      out_d = out_d ^ {{(BYTE_W-1){1'b0}}, inj_err};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         pat_q   <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         lfsr_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         lfsr_q  <= lfsr_d;
         out_q   <= out_d;
         valid_q <= 1'b1;
         phase_q <= phase_d;
      end
   end

   assign prbs_out      = out_q;
   assign prbs_valid    = valid_q;
   assign pattern_phase = phase_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen: table of configurations, a
// bit-serial PRBS15 reference model and an expected-output queue.
module tb_prbs_pattern_gen;
   import prbs_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] pattern;
   logic [3:0]  n;
   logic        inj_err;
   logic [7:0]  prbs_out;
   logic        prbs_valid;
   logic        pattern_phase;
   prbs_state_e dbg_state;

   int checks;
   int errors;
   int zero_run;
   int max_zero_run;
   logic [9:0] exp_q[$];

   typedef struct {
      logic [31:0] pattern;
      logic [3:0]  n;
      int          nprbs;
      bit          mid_change;
   } vec_t;

   vec_t vecs[5];

   prbs_pattern_gen #(.PAT_W(32), .N_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pattern       (pattern),
      .n             (n),
`ifdef PRBS_GEN_ERR_INJ_EN
      .inj_err       (inj_err),
`endif
      .prbs_out      (prbs_out),
      .prbs_valid    (prbs_valid),
      .pattern_phase (pattern_phase),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one bit per step, first bit to MSB
   function automatic void m_step(inout logic [14:0] s, output logic [7:0] b);
      logic fb;
      b = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         fb   = s[14] ^ s[13];
         s    = {s[13:0], fb};
         b[i] = fb;
      end
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got valid/phase/byte=%b/%b/%h, expected %b/%b/%h",
                  name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic push(input logic v, input logic ph, input logic [7:0] b);
      exp_q.push_back({v, ph, b});
   endtask

   // one clock; the DUT output for that edge is compared with the queue head
   task automatic tick(input string name);
      logic [9:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got %h", name, prbs_out);
      end else begin
         e = exp_q.pop_front();
         check(name, {prbs_valid, pattern_phase, prbs_out}, e);
      end
      if (prbs_valid && !pattern_phase && prbs_out == 8'h00) begin
         zero_run++;
         if (zero_run > max_zero_run) max_zero_run = zero_run;
      end else begin
         zero_run = 0;
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         push(1'b0, 1'b0, 8'h00);
         tick("reset");
      end
      rst = 1'b0;
   endtask

   // abort_at >= 0: assert rst at the edge that would emit that pattern byte
   task automatic run_config(input logic [31:0] pat, input logic [3:0] reps,
                             input int nprbs, input bit mid_change,
                             input int abort_at, input bit with_reset);
      logic [14:0] s;
      logic [7:0]  b;
      logic [7:0]  pb[4];
      int          k;
      if (with_reset) do_reset(2);
      pattern = pat;
      n       = reps;
      pb[0] = pat[31:24];
      pb[1] = pat[23:16];
      pb[2] = pat[15:8];
      pb[3] = pat[7:0];
      k = 0;
      for (int r = 0; r < int'(reps); r++) begin
         for (int i = 0; i < 4; i++) begin
            if (k == abort_at) begin
               rst = 1'b1;
               push(1'b0, 1'b0, 8'h00);
               tick("mid_reset");
               rst = 1'b0;
               return;
            end
            push(1'b1, 1'b1, pb[i]);
            tick("pattern_byte");
            if (k == 0 && mid_change) begin
               pattern = $urandom;
               n       = 4'($urandom_range(0, 15));
            end
            k++;
         end
      end
      s = (pat[14:0] == 15'h0) ? 15'h0001 : pat[14:0];
      for (int j = 0; j < nprbs; j++) begin
         m_step(s, b);
         push(1'b1, 1'b0, b);
         tick((j == 0) ? "first_prbs" : "prbs_byte");
         if (reps == 4'd0 && j == 0 && mid_change) begin
            pattern = $urandom;
            n       = 4'($urandom_range(1, 15));
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      pattern = 32'h0;
      n       = 4'h0;
      inj_err = 1'b0;

      vecs[0] = '{pattern: 32'hA5A6A7A8, n: 4'd3,  nprbs: 40, mid_change: 1'b1};
      vecs[1] = '{pattern: 32'h00000000, n: 4'd0,  nprbs: 64, mid_change: 1'b1};
      vecs[2] = '{pattern: 32'h12345678, n: 4'd1,  nprbs: 20, mid_change: 1'b0};
      vecs[3] = '{pattern: 32'hDEADBEEF, n: 4'd15, nprbs: 20, mid_change: 1'b1};
      vecs[4] = '{pattern: $urandom,      n: 4'($urandom_range(0, 5)), nprbs: 30, mid_change: 1'b0};

      for (int v = 0; v < 5; v++) begin
         zero_run     = 0;
         max_zero_run = 0;
         run_config(vecs[v].pattern, vecs[v].n, vecs[v].nprbs, vecs[v].mid_change, -1, 1'b1);
         if (vecs[v].pattern == 32'h0) begin
            checks++;
            if (max_zero_run > 2) begin
               errors++;
               $display("FAIL zero_run: got %0d consecutive 00 bytes, expected at most 2", max_zero_run);
            end
         end
      end

      // PRBS keeps running after the pattern phase
      checks++;
      if (dbg_state !== PRBS) begin
         errors++;
         $display("FAIL final_state: got %0d, expected %0d", dbg_state, PRBS);
      end

      // reset during the second repetition, third byte; then a full restart
      run_config(32'hA5A6A7A8, 4'd3, 0, 1'b0, 6, 1'b1);
      run_config(32'hA5A6A7A8, 4'd3, 8, 1'b0, -1, 1'b0);

      // full period plus wrap, compared bit-exactly to the model
      run_config(32'h5A5AC3E1, 4'd0, 32767 + 16, 1'b0, -1, 1'b1);

`ifdef PRBS_GEN_ERR_INJ_EN
      begin
         logic [14:0] s;
         logic [7:0]  b;
         rst     = 1'b1;
         inj_err = 1'b1;
         push(1'b0, 1'b0, 8'h00);
         tick("inj_in_reset");
         inj_err = 1'b0;
         push(1'b0, 1'b0, 8'h00);
         tick("reset");
         rst     = 1'b0;
         pattern = 32'hA5A6A7A8;
         n       = 4'd2;
         push(1'b1, 1'b1, 8'hA5); tick("inj_pat");
         push(1'b1, 1'b1, 8'hA6); tick("inj_pat");
         inj_err = 1'b1;
         push(1'b1, 1'b1, 8'hA6); tick("inj_pat_flip");
         inj_err = 1'b0;
         push(1'b1, 1'b1, 8'hA8); tick("inj_pat_after");
         push(1'b1, 1'b1, 8'hA5); tick("inj_pat_after");
         push(1'b1, 1'b1, 8'hA6); tick("inj_pat");
         push(1'b1, 1'b1, 8'hA7); tick("inj_pat");
         push(1'b1, 1'b1, 8'hA8); tick("inj_pat");
         s = 15'h27A8;
         for (int j = 0; j < 12; j++) begin
            m_step(s, b);
            inj_err = (j == 5);
            push(1'b1, 1'b0, (j == 5) ? (b ^ 8'h01) : b);
            tick("inj_prbs");
         end
         inj_err = 1'b0;
      end
`endif

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d entries, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Byte-wide stimulus source feeding `Pattern_Detector`: after reset it emits a 32-bit sync pattern `n` times, MSB byte first, then switches to a free-running PRBS15 byte stream. `prbs_out` connects directly to the detector's `prbs_out` input. `pattern` and `n` are shared with the detector so both ends agree on the sync sequence.

## Interface
- `PAT_W`, 32: sync pattern width; must be a multiple of 8.
- `N_W`, 4: width of the repetition count.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `pattern`, in, PAT_W: sync pattern; also provides the PRBS seed.
- `n`, in, N_W: number of pattern repetitions; 0..15.
- `inj_err`, in, 1: error-injection request. Present only when `PRBS_GEN_ERR_INJ_EN` is defined.
- `prbs_out`, out, 8: output byte.
- `prbs_valid`, out, 1: `prbs_out` holds a meaningful byte.
- `pattern_phase`, out, 1: current byte belongs to the sync pattern.

## Operation
- **Reset.** While `rst=1` at a clock edge:
  - `prbs_out=8'h00`, `prbs_valid=0`, `pattern_phase=0`.
  - Counters cleared; FSM goes to `LOAD`.
- **LOAD** (first edge with `rst=0`):
  - Latch `pattern` and `n`. Later changes to either input are ignored until the next reset.
  - If `n!=0`: output `pattern[31:24]`, set `pattern_phase=1`, go to `PAT` with byte index 1 and rep count 0.
  - If `n==0`: seed the LFSR, output the first PRBS byte, go to `PRBS`.
  - `prbs_valid=1` from this edge on.
- **PAT.** One byte per cycle, index 0..3 giving `pattern[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - On index wrap 3→0, increment the rep count.
  - After the last byte of repetition `n`, the next edge seeds the LFSR, outputs the first PRBS byte, sets `pattern_phase=0` and goes to `PRBS`.
- **PRBS.**
  - Polynomial x^15+x^14+1.
  - State `s[14:0]`. One bit step is: `fb=s[14]^s[13]`, then `s={s[13:0],fb}`; the output bit is `fb`.
  - Eight steps are unrolled per cycle. The first generated bit goes to `prbs_out[7]`, the last to `prbs_out[0]`.
  - Seed is `pattern[14:0]`, forced to `15'h0001` if zero.
  - The first PRBS byte is generated from the seed in the same edge as the seed is loaded.
  - This state has no exit except reset.
- **Arithmetic.** The byte index is 2 bits and wraps naturally. The rep counter is N_W bits and is compared to latched `n`; it never overflows because the exit happens at `n`.
- **Reset mid-operation.** `rst` wins over every other event at the same edge. Outputs take reset values at that edge and the sequence restarts from `LOAD`.

## Timing
- All outputs are registered. No combinational path from input to output.
- Latency from reset deassertion: the first byte appears after the first edge with `rst=0`.
- Pattern phase lasts exactly 4·n cycles; the first PRBS byte follows with no gap.
- `prbs_valid` stays high continuously after `LOAD`. There is no back-pressure.
- The PRBS byte sequence period is 32767 cycles. This holds because gcd(8, 32767)=1.

## Configuration
- **Macro:** `PRBS_GEN_ERR_INJ_EN`.
- **Defined:**
  - `inj_err` exists.
  - When `inj_err=1` at an edge where `prbs_valid` will be 1, the byte registered at that edge has bit 0 inverted.
  - Applies in both `PAT` and `PRBS`.
  - LFSR state and counters are unaffected, so the stream resynchronises on the next byte.
  - Ignored during reset.
- **Undefined:** the port and XOR logic are absent; output is always error-free.

## Structure
- Shared package `prbs_pkg`:
  - `PRBS_LEN=15`, `PRBS_TAP_A=14`, `PRBS_TAP_B=13`, `PRBS_SEED_DEF=15'h0001`, `BYTE_W=8`.
  - FSM enum `{LOAD, PAT, PRBS}`.
- Sub-module `prbs_lfsr8`: combinational eight-step unroll. It takes the current state and returns the next state plus the output byte, and is reusable by the detector's checker.

## Test plan
- **Nominal sequence.** `pattern=32'hA5A6A7A8`, `n=3`, release reset → A5,A6,A7,A8 ×3 on consecutive cycles with `pattern_phase=1`. The 13th byte equals the model PRBS byte from seed `15'h27A8`, with `pattern_phase=0`.
- **Detector loopback.** Same settings, feed `prbs_out` into `Pattern_Detector` with the same `pattern` and `n` → `pattern_detected` asserts after the 12th byte.
- **Zero repetitions.** `n=0` → the first byte after reset is PRBS and `pattern_phase` never asserts. With `pattern=0` the seed is `15'h0001`, and the output is never stuck at 00 for more than 2 consecutive bytes.
- **Period and match.** Run 32767+16 PRBS bytes → the sequence matches the reference model bit-exactly and repeats with period 32767.
- **Reset mid-operation.** Assert `rst` during repetition 2, byte 2 → outputs are 00/0/0 at that edge. After release the sequence restarts at A5 with a full n=3 count.
- **Error injection** (macro defined). Pulse `inj_err` on the edge that would produce A7 → output A6, and the next bytes are A8, A5 unchanged. Repeat in PRBS: exactly one byte differs from the model, in bit 0.
